// File: rtl/falling_block_engine.sv
// Per-frame falling block engine: spawns, moves, collision-checks and redraws
// up to NUM_BLOCKS square blocks, streaming one pixel write per cycle.
//
// state | meaning
// IDLE  | waiting for frame_tick with run high
// SLOT  | inspect slot s; load a new block here when spawning
// ERASE | plot the block in colour 000 at its old position
// MOVE  | by += bspd
// CHECK | paddle catch / bottom miss test
// DRAW  | plot the block in its colour at the new position
// SPAWN | plot the freshly loaded block
// NEXT  | advance to the next slot or finish
// DONE  | single cycle end of frame
module falling_block_engine #(
   parameter int NUM_BLOCKS   = 4,
   parameter int BLOCK_SIZE   = 2,
   parameter int SCREEN_W     = 160,
   parameter int SCREEN_H     = 120,
   parameter int PADDLE_Y     = 110,
   parameter int SPAWN_THRESH = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  run,
   input  logic                  frame_tick,
   input  logic [15:0]           rng,
   input  logic [7:0]            paddle_x,
   input  logic [5:0]            paddle_w,
   output logic                  plot,
   output logic [7:0]            x,
   output logic [7:0]            y,
   output logic [2:0]            colour,
   output logic                  busy,
   output logic                  caught,
   output logic                  missed,
   output logic                  overrun,
   output logic [NUM_BLOCKS-1:0] active
);

   localparam int         LANE_W = SCREEN_W / NUM_BLOCKS;
   localparam int         SW     = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
   localparam logic [8:0] SPAN   = 9'(LANE_W - BLOCK_SIZE);
   localparam logic [1:0] LAST   = 2'(BLOCK_SIZE - 1);

   typedef enum logic [3:0] {IDLE, SLOT, ERASE, MOVE, CHECK, DRAW, SPAWN, NEXT, DONE} state_t;

   state_t                  state_q, state_d;
   logic [SW-1:0]           s_q;
   logic [1:0]              row_q, col_q;
   logic [7:0]              bx_q   [NUM_BLOCKS];
   logic [7:0]              by_q   [NUM_BLOCKS];
   logic [2:0]              bcol_q [NUM_BLOCKS];
   logic [1:0]              bspd_q [NUM_BLOCKS];
   logic [NUM_BLOCKS-1:0]   act_q;
   logic                    busy_q, overrun_q, plot_q;
   logic [7:0]              x_q, y_q;
   logic [2:0]              colour_q;

   logic [7:0]              cur_bx, cur_by;
   logic [2:0]              cur_col;
   logic [1:0]              cur_spd;
   logic                    start, pix_last, spawn_ok, hit_catch, hit_miss;
   logic [8:0]              bot, blk_r, pad_r, lane_base, lane_off;
   logic [7:0]              spawn_x;
   logic [2:0]              spawn_col;
   logic [1:0]              spawn_spd;
   logic                    rng_unused;

   assign cur_bx  = bx_q[s_q];
   assign cur_by  = by_q[s_q];
   assign cur_col = bcol_q[s_q];
   assign cur_spd = bspd_q[s_q];

   // Ticks are also refused in the trailing cycle after DONE while busy is still high.
   assign start    = frame_tick && run && !busy_q && (state_q == IDLE);
   assign pix_last = (row_q == LAST) && (col_q == LAST);
   assign spawn_ok = {1'b0, rng[7:4]} < 5'(SPAWN_THRESH);

   assign bot       = {1'b0, cur_by} + 9'(BLOCK_SIZE - 1);
   assign blk_r     = {1'b0, cur_bx} + 9'(BLOCK_SIZE - 1);
   assign pad_r     = {1'b0, paddle_x} + {3'b000, paddle_w} - 9'd1;
   assign hit_catch = (bot >= 9'(PADDLE_Y)) && ({1'b0, cur_bx} <= pad_r) && ({1'b0, paddle_x} <= blk_r);
   assign hit_miss  = bot >= 9'(SCREEN_H - 1);

   assign lane_base = {{(9-SW){1'b0}}, s_q} * 9'(LANE_W);
   assign lane_off  = ({5'd0, rng[3:0]} < SPAN) ? {5'd0, rng[3:0]} : SPAN;
   assign spawn_x   = 8'(lane_base + lane_off);
   assign spawn_col = (rng[10:8] == 3'b000) ? 3'b111 : rng[10:8];
   assign spawn_spd = (rng[12:11] == 2'b00) ? 2'b01 : rng[12:11];
   assign rng_unused = ^rng[15:13];

   always_comb begin
      state_d = state_q;
      caught  = 1'b0;
      missed  = 1'b0;
      case (state_q)
         IDLE:  if (start) state_d = SLOT;
         SLOT: begin
            if (act_q[s_q])   state_d = ERASE;
            else if (spawn_ok) state_d = SPAWN;
            else               state_d = NEXT;
         end
         ERASE: if (pix_last) state_d = MOVE;
         MOVE:  state_d = CHECK;
         CHECK: begin
            if (hit_catch) begin
               caught  = 1'b1;
               state_d = NEXT;
            end else if (hit_miss) begin
               missed  = 1'b1;
               state_d = NEXT;
            end else begin
               state_d = DRAW;
            end
         end
         DRAW, SPAWN: if (pix_last) state_d = NEXT;
         NEXT:  state_d = (s_q == SW'(NUM_BLOCKS - 1)) ? DONE : SLOT;
         DONE:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         s_q       <= '0;
         row_q     <= '0;
         col_q     <= '0;
         act_q     <= '0;
         busy_q    <= 1'b0;
         overrun_q <= 1'b0;
         plot_q    <= 1'b0;
         x_q       <= '0;
         y_q       <= '0;
         colour_q  <= '0;
         for (int i = 0; i < NUM_BLOCKS; i++) begin
            bx_q[i]   <= '0;
            by_q[i]   <= '0;
            bcol_q[i] <= '0;
            bspd_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         busy_q  <= (state_q != IDLE) || start;
         plot_q  <= 1'b0;
         if (frame_tick && busy_q) overrun_q <= 1'b1;
         case (state_q)
            SLOT: begin
               if (!act_q[s_q] && spawn_ok) begin
                  act_q[s_q]  <= 1'b1;
                  by_q[s_q]   <= '0;
                  bx_q[s_q]   <= spawn_x;
                  bcol_q[s_q] <= spawn_col;
                  bspd_q[s_q] <= spawn_spd;
               end
            end
            ERASE, DRAW, SPAWN: begin
               plot_q   <= 1'b1;
               x_q      <= cur_bx + {6'd0, col_q};
               y_q      <= cur_by + {6'd0, row_q};
               colour_q <= (state_q == ERASE) ? 3'b000 : cur_col;
               if (col_q == LAST) begin
                  col_q <= '0;
                  row_q <= (row_q == LAST) ? 2'd0 : row_q + 2'd1;
               end else begin
                  col_q <= col_q + 2'd1;
               end
            end
            MOVE:  by_q[s_q] <= cur_by + {6'd0, cur_spd};
            CHECK: if (hit_catch || hit_miss) act_q[s_q] <= 1'b0;
            NEXT:  if (s_q != SW'(NUM_BLOCKS - 1)) s_q <= s_q + 1'b1;
            DONE:  s_q <= '0;
            default: ;
         endcase
      end
   end

   assign plot    = plot_q;
   assign x       = x_q;
   assign y       = y_q;
   assign colour  = colour_q;
   assign busy    = busy_q;
   assign overrun = overrun_q;
   assign active  = act_q;

endmodule

// File: tb/tb_falling_block_engine.sv
// Bench for falling_block_engine: frame-level model of spawn/move/catch/miss
// rules producing the expected pixel stream, pulse counts and frame length.
module tb_falling_block_engine;
   localparam int NB = 4, BS = 2, LW = 40, PY = 110, SH = 120, TH = 8;

   logic        clk = 1'b0, reset = 1'b1, run = 1'b1, frame_tick = 1'b0;
   logic [15:0] rng = '0;
   logic [7:0]  paddle_x = '0;
   logic [5:0]  paddle_w = 6'd1;
   logic        plot, busy, caught, missed, overrun;
   logic [7:0]  x, y;
   logic [2:0]  colour;
   logic [NB-1:0] active;

   int tests = 0, fails = 0;
   int busy_cnt = 0, plot_cnt = 0, caught_cnt = 0, missed_cnt = 0;
   logic [18:0] first_pix = '0;
   bit chk_en = 1'b0;

   int m_bx[NB], m_by[NB], m_col[NB], m_spd[NB];
   bit m_act[NB];
   int exp_cyc = 0, exp_c = 0, exp_m = 0;
   logic [18:0] exp_q[$];

   always #5 clk = ~clk;

   falling_block_engine #(
      .NUM_BLOCKS(NB), .BLOCK_SIZE(BS), .SCREEN_W(160), .SCREEN_H(SH),
      .PADDLE_Y(PY), .SPAWN_THRESH(TH)
   ) dut (
      .clk(clk), .reset(reset), .run(run), .frame_tick(frame_tick), .rng(rng),
      .paddle_x(paddle_x), .paddle_w(paddle_w), .plot(plot), .x(x), .y(y),
      .colour(colour), .busy(busy), .caught(caught), .missed(missed),
      .overrun(overrun), .active(active)
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
      tests++;
      if (got !== expv) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, got, expv);
      end
   endtask

   function automatic logic [NB-1:0] m_active();
      logic [NB-1:0] v = '0;
      for (int i = 0; i < NB; i++) v[i] = m_act[i];
      return v;
   endfunction

   function automatic void push_block(input int s, input int col);
      for (int r = 0; r < BS; r++)
         for (int c = 0; c < BS; c++)
            exp_q.push_back({8'(m_bx[s] + c), 8'(m_by[s] + r), 3'(col)});
   endfunction

   function automatic void model_clear();
      for (int i = 0; i < NB; i++) begin
         m_bx[i] = 0; m_by[i] = 0; m_col[i] = 0; m_spd[i] = 0; m_act[i] = 1'b0;
      end
      exp_q.delete();
   endfunction

   // One frame by the game rules: pixel list, catch/miss counts and cycle cost.
   function automatic void model_frame(input logic [15:0] r, input int px, input int pw);
      int pr, bot, off;
      exp_q.delete();
      exp_cyc = 2; exp_c = 0; exp_m = 0;
      pr = px + pw - 1;
      for (int s = 0; s < NB; s++) begin
         if (m_act[s]) begin
            push_block(s, 0);
            m_by[s] += m_spd[s];
            bot = m_by[s] + BS - 1;
            if (bot >= PY && m_bx[s] <= pr && px <= m_bx[s] + BS - 1) begin
               exp_c++; m_act[s] = 1'b0; exp_cyc += BS*BS + 4;
            end else if (bot >= SH - 1) begin
               exp_m++; m_act[s] = 1'b0; exp_cyc += BS*BS + 4;
            end else begin
               push_block(s, m_col[s]); exp_cyc += 4 + 2*BS*BS;
            end
         end else if (int'(r[7:4]) < TH) begin
            off = int'(r[3:0]);
            if (off > LW - BS) off = LW - BS;
            m_act[s] = 1'b1;
            m_by[s]  = 0;
            m_bx[s]  = s*LW + off;
            m_col[s] = (r[10:8] == 3'd0) ? 7 : int'(r[10:8]);
            m_spd[s] = (r[12:11] == 2'd0) ? 1 : int'(r[12:11]);
            push_block(s, m_col[s]);
            exp_cyc += 2 + BS*BS;
         end else begin
            exp_cyc += 2;
         end
      end
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         if (busy === 1'b1) busy_cnt++;
         if (caught === 1'b1) caught_cnt++;
         if (missed === 1'b1) missed_cnt++;
         if (plot === 1'b1) begin
            if (plot_cnt == 0) first_pix = {x, y, colour};
            plot_cnt++;
            if (exp_q.size() == 0) begin
               tests++; fails++;
               $display("FAIL plot_extra: got pixel %0h expected no plot", {x, y, colour});
            end else begin
               check("pixel", {13'd0, x, y, colour}, {13'd0, exp_q.pop_front()});
            end
         end
      end
   end

   task automatic zero_counts();
      busy_cnt = 0; plot_cnt = 0; caught_cnt = 0; missed_cnt = 0;
   endtask

   task automatic run_frame(input logic [15:0] r, input logic [7:0] px, input logic [5:0] pw,
                            input bit extra_tick);
      int n;
      rng = r; paddle_x = px; paddle_w = pw;
      model_frame(r, int'(px), int'(pw));
      zero_counts();
      frame_tick = 1'b1;
      @(negedge clk);
      n = 0;
      while (busy === 1'b1 && n < 400) begin
         frame_tick = extra_tick && (n == 3);
         @(negedge clk);
         n++;
      end
      frame_tick = 1'b0;
      tests++;
      if (n >= 400) begin
         fails++;
         $display("FAIL frame_timeout: busy still high after %0d cycles, required low", n);
      end
      repeat (3) @(negedge clk);
      check("plots_missing", exp_q.size(), 0);
      check("busy_cycles", busy_cnt, exp_cyc);
      check("caught_count", caught_cnt, exp_c);
      check("missed_count", missed_cnt, exp_m);
      check("active", {28'd0, active}, {28'd0, m_active()});
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      model_clear();
   endtask

   initial begin
      int n;
      model_clear();
      repeat (2) @(negedge clk);
      reset = 1'b0;
      check("rst_plot", plot, 0);
      check("rst_x", x, 0);
      check("rst_y", y, 0);
      check("rst_colour", colour, 0);
      check("rst_busy", busy, 0);
      check("rst_caught", caught, 0);
      check("rst_missed", missed, 0);
      check("rst_overrun", overrun, 0);
      check("rst_active", active, 0);
      chk_en = 1'b1;

      // Four spawns, speed 1, then fall to the bottom with the paddle out of reach.
      run_frame(16'h0905, 8'd0, 6'd1, 1'b0);
      check("A_busy26", busy_cnt, 26);
      check("A_plots16", plot_cnt, 16);
      check("A_first_pix", first_pix, {8'd5, 8'd0, 3'd1});
      check("A_active", active, 4'hF);
      for (int k = 1; k <= 117; k++) run_frame(16'h0080, 8'd0, 6'd1, 1'b0);
      check("A_bot118_active", active, 4'hF);
      run_frame(16'h0080, 8'd0, 6'd1, 1'b0);
      check("A_missed4", missed_cnt, 4);
      check("A_miss_busy", busy_cnt, 34);
      check("A_miss_plots", plot_cnt, 16);
      check("A_miss_active", active, 4'h0);
      run_frame(16'h0080, 8'd0, 6'd1, 1'b0);
      check("A_empty_busy", busy_cnt, 10);
      check("A_empty_plots", plot_cnt, 0);
      check("A_no_overrun", overrun, 0);

      // Speed 3 blocks at bx 15/55/95/135; paddle edge cases near the bottom.
      do_reset();
      run_frame(16'h187F, 8'd0, 6'd8, 1'b0);
      check("B_first_pix", first_pix, {8'd15, 8'd0, 3'd7});
      for (int k = 1; k <= 36; k++) run_frame(16'h0080, 8'd0, 6'd8, 1'b0);
      run_frame(16'h0080, 8'd57, 6'd38, 1'b0);
      check("B_edges_nocatch", caught_cnt, 0);
      run_frame(16'h0080, 8'd56, 6'd1, 1'b0);
      check("B_left_edge_catch", caught_cnt, 1);
      check("B_active_1101", active, 4'b1101);
      run_frame(16'h1234, 8'd90, 6'd6, 1'b0);
      check("B_right_edge_catch", caught_cnt, 1);
      check("B_active_1011", active, 4'b1011);
      run_frame(16'h0080, 8'd10, 6'd6, 1'b0);
      check("B_catch_priority", caught_cnt, 1);
      check("B_miss_one", missed_cnt, 1);
      check("B_active_0010", active, 4'b0010);

      run_frame(16'h0080, 8'd0, 6'd8, 1'b1);
      check("overrun_set", overrun, 1);

      run = 1'b0;
      zero_counts();
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      repeat (10) @(negedge clk);
      check("run_low_busy", busy_cnt, 0);
      check("run_low_plots", plot_cnt, 0);
      run = 1'b1;

      // Reset in the middle of a coloured draw burst.
      chk_en = 1'b0;
      rng = 16'h0080; paddle_x = 8'd0; paddle_w = 6'd8;
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      n = 0;
      while (!(plot === 1'b1 && colour !== 3'd0) && n < 200) begin
         @(negedge clk);
         n++;
      end
      tests++;
      if (n >= 200) begin
         fails++;
         $display("FAIL draw_wait: no draw plot within %0d cycles, required one", n);
      end
      reset = 1'b1;
      @(negedge clk);
      check("midrst_plot", plot, 0);
      check("midrst_active", active, 0);
      check("midrst_busy", busy, 0);
      check("midrst_overrun", overrun, 0);
      reset = 1'b0;
      model_clear();
      repeat (2) @(negedge clk);
      chk_en = 1'b1;
      run_frame(16'h0905, 8'd0, 6'd1, 1'b0);
      check("C_busy26", busy_cnt, 26);
      check("C_plots16", plot_cnt, 16);
      check("C_first_pix", first_pix, {8'd5, 8'd0, 3'd1});

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/falling_block_engine.md
# falling_block_engine

Parametrised successor to the single-purpose ball logic in the catcher game: a per-frame engine that spawns, moves, collision-checks and redraws up to NUM_BLOCKS square blocks and streams pixel writes to the 160x120 VGA adapter.

- Adds over the previous game logic:
  - per-block speed;
  - paddle catch detection, with separate caught and missed events;
  - configurable block size and lane count;
  - a frame-overrun flag.
- Instantiated inside the game controller. The controller owns paddle drawing, score and timer, and muxes this block's plot stream with its own.

## Interface
Parameters:
- NUM_BLOCKS, 4: number of block slots (1..10). Slot i is confined to lane i.
- BLOCK_SIZE, 2: block edge length in pixels (1..4).
- SCREEN_W, 160: playfield width. Lane width LANE_W = SCREEN_W / NUM_BLOCKS, which must be ≥ BLOCK_SIZE.
- SCREEN_H, 120: playfield height.
- PADDLE_Y, 110: top row of the paddle.
- SPAWN_THRESH, 4: spawn when rng[7:4] < SPAWN_THRESH, range 0..16. A value of 0 disables spawning.

Ports:
- clk, in, 1: system clock (50 MHz).
- reset, in, 1: synchronous, active-high.
- run, in, 1: when low, frame_tick is ignored.
- frame_tick, in, 1: one-cycle pulse that starts a frame update.
- rng, in, 16: free-running random value, sampled when a slot spawns.
- paddle_x, in, 8: leftmost paddle column.
- paddle_w, in, 6: paddle width in pixels (≥1).
- plot, out, 1: pixel write strobe.
- x, out, 8: pixel column.
- y, out, 8: pixel row (≤ SCREEN_H-1).
- colour, out, 3: pixel colour.
- busy, out, 1: high from frame start to DONE inclusive.
- caught, out, 1: one-cycle pulse per block that hits the paddle.
- missed, out, 1: one-cycle pulse per block that reaches the bottom.
- overrun, out, 1: sticky. Set when a frame_tick arrives while busy; cleared only by reset.
- active, out, NUM_BLOCKS: per-slot active flags.

## Operation
- Per-slot registers: bx[7:0], by[7:0], bcol[2:0], bspd[1:0], act.
- FSM states: IDLE, SLOT, ERASE, MOVE, CHECK, DRAW, SPAWN, NEXT, DONE.
- IDLE → SLOT when frame_tick && run. Slot index s = 0 on entry.
- SLOT:
  - If act[s] → ERASE.
  - Else → SPAWN.
- ERASE: plot BLOCK_SIZE² pixels with colour 000, row-major, at (bx+c, by+r). Then → MOVE.
- MOVE: by ← by + bspd, 8-bit add; by ≤ 119 so no wrap. → CHECK.
- CHECK: let bot = by + BLOCK_SIZE - 1.
  - Caught when bot ≥ PADDLE_Y and the ranges [bx, bx+BLOCK_SIZE-1] and [paddle_x, paddle_x+paddle_w-1] overlap. Action: act ← 0, pulse caught, → NEXT.
  - Otherwise, missed when bot ≥ SCREEN_H-1. Action: act ← 0, pulse missed, → NEXT.
  - Otherwise → DRAW.
  - Caught takes priority over missed.
- DRAW: plot BLOCK_SIZE² pixels with colour bcol. Then → NEXT.
- SPAWN: if rng[7:4] < SPAWN_THRESH, then:
  - act ← 1, by ← 0;
  - bx ← s·LANE_W + min(rng[3:0], LANE_W-BLOCK_SIZE);
  - bcol ← rng[10:8], with 000 mapped to 111;
  - bspd ← rng[12:11], with 00 mapped to 01;
  - then plot the block in the same way as DRAW.
  - If no spawn occurs, go to NEXT with no plot.
- NEXT:
  - If s == NUM_BLOCKS-1 → DONE.
  - Else s ← s+1 → SLOT.
- DONE: single cycle, → IDLE.
- A block spawned this frame does not move until the next frame.
- Arithmetic widths:
  - Coordinate sums are computed 9 bits wide and compared unsigned.
  - The paddle right edge paddle_x+paddle_w-1 is 9 bits.

## Timing
- Reset values:
  - plot=0, x=0, y=0, colour=000;
  - busy=0, caught=0, missed=0, overrun=0;
  - active=0, all slot registers 0;
  - FSM in IDLE.
- Reset wins over any concurrent event. Reset mid-frame aborts within one cycle with no further plots.
- Plot outputs: x, y and colour are registered and valid in the same cycle as plot. One pixel is written per cycle, with no gaps inside a block.
- Cycle cost per frame:
  - 2 cycles fixed: IDLE→SLOT and DONE.
  - Per active surviving slot: 3 cycles (SLOT, MOVE, CHECK) + 2·BLOCK_SIZE² pixel cycles + 1 (NEXT).
  - Per caught or missed slot: BLOCK_SIZE² + 4.
  - Per spawning slot: 2 + BLOCK_SIZE².
  - Per empty slot with no spawn: 2.
- busy rises the cycle after frame_tick and falls the cycle after DONE.
- caught and missed pulse in the CHECK cycle. Simultaneous events cannot occur, since slots are serialised.
- frame_tick while busy:
  - the tick is dropped;
  - overrun ← 1.
- run falling mid-frame: the current frame completes; later ticks are ignored.

## Test plan
- Reset, then one tick with run=1, SPAWN_THRESH=16, rng=16'h0905, NUM_BLOCKS=4, BLOCK_SIZE=2 → 4 spawns:
  - slot0 at bx=5 (0 + min(5, 38)), colour 001, speed 1;
  - 16 plots total;
  - busy high for 2+4·6 = 26 cycles.
- Block with bspd=3 at by=105, bx=72, paddle_x=70, paddle_w=12 → after one tick by=108, bot=109. Second tick: by=111 ≥ 110 with overlap → caught pulse once, act=0, only the 4 erase plots.
- Same block with paddle_x=0, paddle_w=8 → no catch. It keeps falling until bot ≥ 119 → missed pulse, act=0, no draw in that frame.
- Paddle edge: bx=80, paddle_x=81-BLOCK_SIZE... set paddle right edge = bx-1 (79) → no catch. With the edge at 80 → catch.
- Tick asserted during busy → overrun=1 and frame count unchanged. Reset → overrun=0.
- Assert reset during a DRAW plot burst → next cycle plot=0, active=0, busy=0. Next tick behaves as from power-up.
